// File: rtl/exu_md.sv
// exu_md: execute stage with a registered valid/ready output and an
// iterative RV M-extension path (one multiply or divide bit per cycle).
// Non-M results and M special cases finish in one cycle; other M ops run
// for XLEN iterations in BUSY, then are sign-fixed and loaded from DONE.
module exu_md #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            e_valid_i,
  output logic            e_ready_o,
  input  logic            is_md_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic [XLEN-1:0] npc_i,
  input  logic            cnd_i,
  output logic            e_valid_o,
  input  logic            e_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic [XLEN-1:0] npc_o,
  output logic            cnd_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic              s1_q, s2_q;
  logic [XLEN-1:0]   opd_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0]   hi_q;    // product high half / partial remainder
  logic [XLEN-1:0]   lo_q;    // multiplier bits / dividend bits -> quotient
  logic [XLEN-1:0]   npc_q;
  logic [CNT_W-1:0]  cnt;

  logic              out_free, accept, cnt_last;
  logic              s1_sgn, s2_sgn, s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf, md_special, md_start;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, md_res;
  logic              load_fast, load_md;

  // The output slot is free when empty or draining this cycle.
  assign out_free  = !e_valid_o || e_ready_i;
  assign e_ready_o = (state == IDLE) && out_free;
  assign accept    = e_valid_i && e_ready_o;
  assign cnt_last  = (cnt == CNT_W'(XLEN - 1));

  // Operand decode: sign flags exist only for the signed operands of each op.
  always_comb begin
    s1_sgn      = (md_op_i != 3'd3) && (md_op_i != 3'd5) && (md_op_i != 3'd7);
    s2_sgn      = (md_op_i == 3'd0) || (md_op_i == 3'd1) ||
                  (md_op_i == 3'd4) || (md_op_i == 3'd6);
    s1          = s1_sgn && src1_i[XLEN-1];
    s2          = s2_sgn && src2_i[XLEN-1];
    mag1        = s1 ? -src1_i : src1_i;
    mag2        = s2 ? -src2_i : src2_i;
    div_zero    = (src2_i == '0);
    div_ovf     = ((md_op_i == 3'd4) || (md_op_i == 3'd6)) &&
                  (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1);
    md_special  = md_op_i[2] && (div_zero || div_ovf);
    special_res = div_zero ? (md_op_i[1] ? src1_i : '1)
                           : (md_op_i[1] ? '0 : src1_i);
    md_start    = accept && is_md_i && !md_special;
    load_fast   = accept && !md_start;
    load_md     = (state == DONE) && out_free;
  end

  // One iteration of shift-add multiply and restoring divide, plus final sign fix.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opd_q};
    prod     = {hi_q, lo_q};
    prod_s   = (s1_q ^ s2_q) ? -prod : prod;
    quo_s    = (s1_q ^ s2_q) ? -lo_q : lo_q;
    rem_s    = s1_q ? -hi_q : hi_q;
    if (op_q[2])
      md_res = op_q[1] ? rem_s : quo_s;
    else
      md_res = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; DONE waits for the output slot to free up.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_start) state_nxt = BUSY;
      BUSY:    if (cnt_last) state_nxt = DONE;
      DONE:    if (out_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iterative datapath: latch magnitudes on start, step once per BUSY cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      op_q  <= '0;
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      opd_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      npc_q <= '0;
    end else if (md_start) begin
      cnt   <= '0;
      op_q  <= md_op_i;
      s1_q  <= s1;
      s2_q  <= s2;
      opd_q <= md_op_i[2] ? mag2 : mag1;
      hi_q  <= '0;
      lo_q  <= md_op_i[2] ? mag1 : mag2;
      npc_q <= npc_i;
    end else if (state == BUSY) begin
      cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
      if (op_q[2]) begin
        if (!div_diff[XLEN]) begin
          hi_q <= div_diff[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= div_sh[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Output register: load a new result, else drop valid once it transfers.
  always_ff @(posedge clock) begin
    if (reset) begin
      e_valid_o <= 1'b0;
      res_o     <= '0;
      npc_o     <= '0;
      cnd_o     <= 1'b0;
    end else if (load_fast) begin
      e_valid_o <= 1'b1;
      res_o     <= is_md_i ? special_res : alu_res_i;
      npc_o     <= npc_i;
      cnd_o     <= is_md_i ? 1'b0 : cnd_i;
    end else if (load_md) begin
      e_valid_o <= 1'b1;
      res_o     <= md_res;
      npc_o     <= npc_q;
      cnd_o     <= 1'b0;
    end else if (e_ready_i) begin
      e_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exu_md.sv
// tb_exu_md: directed and randomized checks of exu_md against a plain
// arithmetic model of the RV M-extension results and the handshake timing.
module tb_exu_md;

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            e_valid_i, e_ready_o, is_md_i, cnd_i;
  logic [2:0]      md_op_i;
  logic [XLEN-1:0] src1_i, src2_i, alu_res_i, npc_i;
  logic            e_valid_o, e_ready_i, cnd_o;
  logic [XLEN-1:0] res_o, npc_o;

  int n_cmp = 0;
  int n_err = 0;

  exu_md #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .e_valid_i(e_valid_i), .e_ready_o(e_ready_o),
    .is_md_i(is_md_i), .md_op_i(md_op_i),
    .src1_i(src1_i), .src2_i(src2_i),
    .alu_res_i(alu_res_i), .npc_i(npc_i), .cnd_i(cnd_i),
    .e_valid_o(e_valid_o), .e_ready_i(e_ready_i),
    .res_o(res_o), .npc_o(npc_o), .cnd_o(cnd_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV M-extension result from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue one instruction (called at posedge+1 with e_ready_i = 1), wait for its
  // result and check latency, result, npc and cnd.
  task automatic do_op(input string tag, input logic md, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] alu, input logic [31:0] npc, input logic cnd);
    logic        sp;
    int          exp_lat, lat;
    logic [31:0] exp_res;
    sp      = op[2] && ((b == 0) ||
              ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat = (!md || sp) ? 1 : XLEN + 2;
    exp_res = md ? ref_md(op, a, b) : alu;
    check({tag, "_rdy_in"}, {31'b0, e_ready_o}, 32'd1);
    e_valid_i = 1'b1; is_md_i = md; md_op_i = op; src1_i = a; src2_i = b;
    alu_res_i = alu; npc_i = npc; cnd_i = cnd;
    @(posedge clock); #1;
    e_valid_i = 1'b0;
    lat = 1;
    while (!e_valid_o && lat < 100) begin
      check({tag, "_busy_rdy"}, {31'b0, e_ready_o}, 32'd0);
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, res_o, exp_res);
    check({tag, "_npc"}, npc_o, npc);
    check({tag, "_cnd"}, {31'b0, cnd_o}, {31'b0, md ? 1'b0 : cnd});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom_range(0, 20);
    endcase
  endfunction

  initial begin
    logic [31:0] held_res, held_npc;
    int          lat;
    logic        seen;

    reset = 1'b1; e_valid_i = 1'b0; e_ready_i = 1'b1; is_md_i = 1'b0; md_op_i = '0;
    src1_i = '0; src2_i = '0; alu_res_i = '0; npc_i = '0; cnd_i = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", {31'b0, e_valid_o}, 32'd0);
    check("rst_res", res_o, 32'd0);
    check("rst_npc", npc_o, 32'd0);
    check("rst_cnd", {31'b0, cnd_o}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_rdy", {31'b0, e_ready_o}, 32'd1);

    // Back-to-back non-M stream.
    for (int i = 1; i <= 3; i++) begin
      e_valid_i = 1'b1; is_md_i = 1'b0; alu_res_i = 32'(i);
      npc_i = 32'h1000 + 32'(4 * i); cnd_i = i[0];
      @(posedge clock); #1;
      check("str_valid", {31'b0, e_valid_o}, 32'd1);
      check("str_res", res_o, 32'(i));
      check("str_npc", npc_o, 32'h1000 + 32'(4 * i));
      check("str_cnd", {31'b0, cnd_o}, {31'b0, i[0]});
    end
    e_valid_i = 1'b0;
    @(posedge clock); #1;
    check("str_drain", {31'b0, e_valid_o}, 32'd0);

    // Directed M-extension cases.
    do_op("mul",    1, 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 32'h2000, 1);
    do_op("mulh",   1, 3'd1, 32'hFFFF_FFFE, 32'd3, 0, 32'h2004, 1);
    do_op("mulhu",  1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h2008, 0);
    do_op("mulhsu", 1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h200C, 0);
    do_op("div",    1, 3'd4, 32'hFFFF_FFF9, 32'd2, 0, 32'h2010, 0);
    do_op("rem",    1, 3'd6, 32'hFFFF_FFF9, 32'd2, 0, 32'h2014, 0);
    do_op("divu",   1, 3'd5, 32'd100, 32'd7, 0, 32'h2018, 0);
    do_op("remu",   1, 3'd7, 32'd100, 32'd7, 0, 32'h201C, 0);
    do_op("div0",   1, 3'd4, 32'd5, 32'd0, 0, 32'h2020, 1);
    do_op("remu0",  1, 3'd7, 32'd5, 32'd0, 0, 32'h2024, 1);
    do_op("divovf", 1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h2028, 0);
    do_op("removf", 1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h202C, 0);

    // Randomized mix of M and non-M instructions.
    for (int i = 0; i < 24; i++) begin
      logic md;
      md = ($urandom_range(0, 3) != 0);
      do_op("rnd", md, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // Back-pressure: let the last result drain, then hold a fresh one.
    @(posedge clock); #1;
    e_ready_i = 1'b0;
    e_valid_i = 1'b1; is_md_i = 1'b0; alu_res_i = 32'h1234_5678; npc_i = 32'h300; cnd_i = 1'b1;
    @(posedge clock); #1;
    e_valid_i = 1'b0;
    held_res = 32'h1234_5678; held_npc = 32'h300;
    check("bp_valid", {31'b0, e_valid_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("bp_res_hold", res_o, held_res);
      check("bp_npc_hold", npc_o, held_npc);
      check("bp_valid_hold", {31'b0, e_valid_o}, 32'd1);
      check("bp_rdy", {31'b0, e_ready_o}, 32'd0);
    end
    // Releasing the sink while a DIV is offered: transfer and accept on one edge.
    e_valid_i = 1'b1; is_md_i = 1'b1; md_op_i = 3'd4;
    src1_i = 32'hFFFF_FFF9; src2_i = 32'd2; npc_i = 32'h304; e_ready_i = 1'b1;
    @(posedge clock); #1;
    e_valid_i = 1'b0; e_ready_i = 1'b0;
    check("bp_xfer", {31'b0, e_valid_o}, 32'd0);
    check("bp_div_busy", {31'b0, e_ready_o}, 32'd0);
    lat = 1;
    while (!e_valid_o && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check("bp_div_lat", 32'(lat), 32'(XLEN + 2));
    check("bp_div_res", res_o, 32'hFFFF_FFFD);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("bp_div_hold", res_o, 32'hFFFF_FFFD);
      check("bp_div_npc", npc_o, 32'h304);
      check("bp_div_rdy", {31'b0, e_ready_o}, 32'd0);
    end
    e_ready_i = 1'b1;
    @(posedge clock); #1;
    check("bp_div_xfer", {31'b0, e_valid_o}, 32'd0);

    // Reset in the middle of an iterative DIV.
    e_valid_i = 1'b1; is_md_i = 1'b1; md_op_i = 3'd5;
    src1_i = 32'd1000; src2_i = 32'd3; npc_i = 32'h400;
    @(posedge clock); #1;
    e_valid_i = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_valid", {31'b0, e_valid_o}, 32'd0);
    check("abort_rdy", {31'b0, e_ready_o}, 32'd1);
    check("abort_res", res_o, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (e_valid_o) seen = 1'b1;
    end
    check("abort_no_result", {31'b0, seen}, 32'd0);
    do_op("post_rst", 1, 3'd0, 32'd12345, 32'd678, 0, 32'h500, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
